layer_serializer: RTL
=====================

Name: layer_serializer

Overview:
- Converts one layer's parallel neuron results back into the serial word stream that the next layer's neurons consume, one word per cycle.
- Sits between a layer's outputs (`x_out` / `o_valid`) and the next layer's `x_in` / `x_valid`.
- Captures the whole result vector in a single cycle, then emits neuron 0 first through neuron NN-1 last.
- Supports downstream backpressure and flags any vector it has to drop.

Parameters:
- NN, 30, number of neurons (words) per captured vector; legal range 1 and up.
- dataWidth, 16, width of each word in bits.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  NN  per-neuron output valids from the producing layer; bit 0 is the capture strobe.
- in_data  input  NN*dataWidth  packed results; word i is in_data[i*dataWidth +: dataWidth].
- out_ready  input  1  downstream can accept a word this cycle; tie to 1 when feeding neurons directly.
- out_valid  output  1  out_data holds a valid word.
- out_data  output  dataWidth  current serialized word.
- out_last  output  1  current word is word NN-1 of its vector.
- busy  output  1  a vector is held and not yet fully sent.
- overrun  output  1  sticky flag; a vector was dropped while busy.

Behaviour:
- Reset (rst=1 at a clock edge):
  - out_valid=0, out_data=0, out_last=0, busy=0, overrun=0.
  - Word counter=0, hold register cleared, FSM goes to IDLE.
  - Reset mid-vector discards the remaining words; no partial output follows.
- FSM states: IDLE, SEND. Internal word counter cnt is clog2(NN) bits wide, minimum 1 bit.
- IDLE:
  - When in_valid[0]=1, latch all of in_data into the hold register, set cnt=0 and move to SEND.
  - in_valid[NN-1:1] are ignored; all neurons of a layer assert valid in the same cycle.
- SEND:
  - out_valid=1, busy=1.
  - out_data = hold word cnt.
  - out_last = (cnt == NN-1).
- Latency: the first word appears with out_valid=1 in the cycle after the capture edge (1-cycle latency).
- Handshake:
  - A word transfers on a rising edge where out_valid=1 and out_ready=1.
  - On transfer with cnt<NN-1: cnt increments.
  - On transfer with cnt=NN-1: the vector is complete and the FSM returns to IDLE.
  - While out_ready=0, out_data, out_last and cnt hold stable; out_valid is never withdrawn without a transfer.
- Simultaneous capture and last-word transfer:
  - If in_valid[0]=1 in the same cycle as the final transfer, the new vector is captured and the FSM stays in SEND with cnt=0.
  - There is no idle bubble between vectors.
- Overrun:
  - If in_valid[0]=1 in SEND and it is not the final-transfer cycle, the new vector is dropped.
  - The hold register and stream are unaffected; overrun is set to 1 and stays 1 until rst.
- Outputs when IDLE: out_valid=0, out_last=0, out_data=0, busy=0.
- NN=1: every vector is one word with out_last=1; the counter never increments.
- All outputs are registered or decoded only from registered state; there is no combinational path from in_* or out_ready to out_valid.

Test Plan:
- Basic (NN=4, dataWidth=16): in_data={0x0004,0x0003,0x0002,0x0001}, in_valid=4'hF for 1 cycle, out_ready=1 -> out_data 0x0001,0x0002,0x0003,0x0004 on the 4 cycles after capture; out_last=1 only with 0x0004; busy falls with the last transfer.
- Backpressure: same vector, out_ready held 0 for 3 cycles after word 1 -> word 0x0002 with out_valid=1 held stable for those 3 cycles; the full sequence is unchanged and no words are lost or duplicated.
- Back-to-back: assert the second vector {0x00D0,0x00C0,0x00B0,0x00A0} exactly on the final-transfer cycle of the first -> 0x00A0 appears on the very next cycle with no gap; overrun stays 0.
- Overrun: assert a new vector while cnt=1 -> the original stream completes unchanged, the new data is never emitted, and overrun=1 persists until rst.
- Reset mid-stream: assert rst after word 2 -> next cycle out_valid=0, out_data=0, busy=0, overrun=0; a new capture afterwards starts again at word 0.
- NN=1 build: in_data=0x7FFF captured -> one cycle later out_valid=1, out_data=0x7FFF, out_last=1; back to IDLE after the transfer.

Source files
------------

// File: rtl/layer_serializer.sv
// layer_serializer: captures one layer's NN parallel results in a single
// cycle and replays them one word per cycle (neuron 0 first) towards the
// next layer, honouring downstream backpressure. A vector that arrives
// while the previous one is still being sent is dropped and flagged.
module layer_serializer #(
  parameter int NN        = 30,
  parameter int dataWidth = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NN-1:0]             in_valid,
  input  logic [NN*dataWidth-1:0]   in_data,
  input  logic                      out_ready,
  output logic                      out_valid,
  output logic [dataWidth-1:0]      out_data,
  output logic                      out_last,
  output logic                      busy,
  output logic                      overrun
);

  // Counter is at least one bit so that NN=1 still elaborates cleanly.
  localparam int              CW   = (NN > 1) ? $clog2(NN) : 1;
  localparam logic [CW-1:0]   LAST = CW'(NN - 1);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SEND = 1'b1;

  logic [0:0]              state;
  logic [CW-1:0]           cnt;
  logic [NN*dataWidth-1:0] hold;

  logic sending;
  logic xfer;
  logic final_xfer;
  logic capture;

  // Only bit 0 is the capture strobe; the other per-neuron valids are
  // redundant because a whole layer completes in the same cycle.
  logic unused_valid;
  assign unused_valid = ^in_valid;

  assign sending    = (state == SEND);
  assign xfer       = sending && out_ready;
  assign final_xfer = xfer && (cnt == LAST);
  // A new vector is accepted when idle, or on the cycle the last word
  // leaves, so consecutive vectors stream with no idle bubble.
  assign capture    = in_valid[0] && (!sending || final_xfer);

  // Sequential state: capture, word advance, and the sticky overrun flag.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      // NOTE: the hold register is ordinary flops, not a RAM, so clearing
      // it on reset is cheap and keeps stale data out of any later debug.
      hold    <= '0;
      overrun <= 1'b0;
    end else begin
      if (capture) begin
        hold  <= in_data;
        cnt   <= '0;
        state <= SEND;
      end else if (final_xfer) begin
        cnt   <= '0;
        state <= IDLE;
      end else if (xfer) begin
        cnt   <= cnt + 1'b1;
      end

      if (in_valid[0] && sending && !final_xfer) begin
        overrun <= 1'b1;
      end
    end
  end

  // Output decode from registered state only; zeros while idle.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    out_valid = sending;
    busy      = sending;
    out_last  = 1'b0;
    out_data  = '0;
    if (sending) begin
      out_last = (cnt == LAST);
      out_data = hold[int'(cnt) * dataWidth +: dataWidth];
    end
  end

endmodule
